// File: rtl/alu_seq_32.sv
// Sequential 32-bit ALU: single-edge logic/arithmetic ops and a WIDTH-cycle
// shift-add multiplier, with a registered result, overflow and done pulse.
module alu_seq_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2
  } state_t;

  state_t           state_r;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] r_r;
  logic             ovf_r;
  logic             done_r;
  logic             busy_r;

  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_ovf_s;
  logic             slt_s;
  logic [WIDTH-1:0] mul_next_s;

  // Signed overflow: operands (B already sign-adjusted for SUB) agree but result sign flips.
  function automatic logic signed_ovf(input logic sa, input logic sb_eff, input logic sr);
    signed_ovf = (sa == sb_eff) && (sr != sa);
  endfunction

  // Single-edge ALU result and the next shift-add partial product.
  always_comb begin
    sum_s      = a_r + b_r;
    diff_s     = a_r - b_r;
    alu_ovf_s  = 1'b0;
    // Differing signs decide SLT directly, so an overflowing difference cannot mislead it.
    if (a_r[WIDTH-1] != b_r[WIDTH-1]) begin
      slt_s = a_r[WIDTH-1];
    end else begin
      slt_s = diff_s[WIDTH-1];
    end
    case (op_r)
      3'b000: alu_res_s = a_r & b_r;
      3'b001: alu_res_s = a_r | b_r;
      3'b010: begin
        alu_res_s = sum_s;
        alu_ovf_s = signed_ovf(a_r[WIDTH-1], b_r[WIDTH-1], sum_s[WIDTH-1]);
      end
      3'b011: begin
        alu_res_s = diff_s;
        alu_ovf_s = signed_ovf(a_r[WIDTH-1], ~b_r[WIDTH-1], diff_s[WIDTH-1]);
      end
      3'b100: alu_res_s = a_r ^ b_r;
      3'b101: alu_res_s = ~(a_r | b_r);
      3'b110: alu_res_s = {{(WIDTH-1){1'b0}}, slt_s};
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
    if (b_r[0]) begin
      mul_next_s = acc_r + a_r;
    end else begin
      mul_next_s = acc_r;
    end
  end

  // Control FSM, operand capture, multiplier iteration and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      op_r    <= 3'b000;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      acc_r   <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      r_r     <= {WIDTH{1'b0}};
      ovf_r   <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r    <= op;
            a_r     <= A;
            b_r     <= B;
            acc_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= (op == 3'b111) ? MUL : EXEC;
          end
        end
        EXEC: begin
          r_r     <= alu_res_s;
          ovf_r   <= alu_ovf_s;
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        MUL: begin
          acc_r <= mul_next_s;
          a_r   <= {a_r[WIDTH-2:0], 1'b0};
          b_r   <= {1'b0, b_r[WIDTH-1:1]};
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            r_r     <= mul_next_s;
            ovf_r   <= 1'b0;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign R    = r_r;
  assign ovf  = ovf_r;
  assign done = done_r;
  assign busy = busy_r;
  assign zero = (r_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_alu_seq_32.sv
// Scoreboard bench for alu_seq_32: directed corner vectors plus random traffic,
// checked against an arithmetic reference model by a negedge monitor.
module tb_alu_seq_32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] A = 32'h0;
  logic [31:0] B = 32'h0;
  logic [31:0] R;
  logic        busy, done, ovf, zero;

  alu_seq_32 #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
    .R(R), .busy(busy), .done(done), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic        ovf;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] hold_r = 32'h0;
  logic        hold_ovf = 1'b0;
  logic        prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, s;
    sa = $signed(a);
    sb = $signed(b);
    e.ovf = 1'b0;
    e.lat = (o == 3'd7) ? 32 : 1;
    e.acc = 0;
    case (o)
      3'd0: e.r = a & b;
      3'd1: e.r = a | b;
      3'd2: begin
        s = sa + sb;
        e.r = s[31:0];
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd3: begin
        s = sa - sb;
        e.r = s[31:0];
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd4: e.r = a ^ b;
      3'd5: e.r = ~(a | b);
      3'd6: e.r = (sa < sb) ? 32'd1 : 32'd0;
      default: e.r = a * b;
    endcase
    return e;
  endfunction

  // Called just after a rising edge; waits for IDLE, then presents one start pulse.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   t;
    t = 0;
    while (busy === 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (busy !== 1'b0) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_wait: busy stuck at %b, required 0", busy);
    end
    e = model(o, a, b);
    e.acc = cyc + 1;
    q.push_back(e);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); A = $urandom; B = $urandom;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h7FFFFFFF;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pop and compare on every done, otherwise check held outputs and busy.
  always @(negedge clk) begin
    exp_t me;
    if (rst_n) begin
      if (done) begin
        chk("done_gap", {31'd0, prev_done}, 32'd0);
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_done: done=1 with no operation outstanding (cycle %0d)", cyc);
        end else begin
          me = q.pop_front();
          chk("result", R, me.r);
          chk("ovf", {31'd0, ovf}, {31'd0, me.ovf});
          chk("zero", {31'd0, zero}, {31'd0, (me.r == 32'd0)});
          chk("latency", 32'(cyc - me.acc), 32'(me.lat));
          chk("busy_at_done", {31'd0, busy}, 32'd0);
          hold_r = me.r;
          hold_ovf = me.ovf;
        end
      end else begin
        chk("hold_r", R, hold_r);
        chk("hold_ovf", {31'd0, ovf}, {31'd0, hold_ovf});
        if (q.size() > 0 && cyc > q[0].acc) chk("busy_inflight", {31'd0, busy}, 32'd1);
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    exp_t e;
    #12;
    chk("rst_r", R, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corners
    issue(3'd6, 32'd7, 32'd32);
    issue(3'd6, 32'd5, 32'hFFFFFFFD);
    issue(3'd6, 32'hFFFFFFFC, 32'hFFFFFFFD);
    issue(3'd6, 32'hFFFFFFFD, 32'hFFFFFFFC);
    issue(3'd6, 32'h80000000, 32'd1);
    issue(3'd6, 32'h7FFFFFFF, 32'h80000000);
    issue(3'd2, 32'h7FFFFFFF, 32'd1);
    issue(3'd3, 32'd5, 32'd5);
    issue(3'd3, 32'h80000000, 32'd1);
    issue(3'd7, 32'd15, 32'd16);
    issue(3'd7, 32'hFFFFFFFD, 32'd7);

    // start during MUL must be ignored
    issue(3'd7, 32'd1234, 32'd5678);
    repeat (5) @(posedge clk);
    #1 start = 1'b1; op = 3'd2; A = 32'd1; B = 32'd1;
    @(posedge clk); #1 start = 1'b0;

    // Reset mid-MULT aborts without done
    issue(3'd7, 32'hDEADBEEF, 32'h12345678);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    hold_r = 32'd0;
    hold_ovf = 1'b0;
    chk("abort_r", R, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_zero", {31'd0, zero}, 32'd1);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(3'd2, 32'd2, 32'd3);

    // Back-to-back with start held high across done
    t = 0;
    while (busy === 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
    e = model(3'd2, 32'd100, 32'hFFFFFFF0);
    e.acc = cyc + 1;
    q.push_back(e);
    e.acc = cyc + 3;
    q.push_back(e);
    start = 1'b1; op = 3'd2; A = 32'd100; B = 32'hFFFFFFF0;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    t = 0;
    while (q.size() > 0 && t < 200) begin @(posedge clk); t++; end
    if (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d operations never completed, required 0", q.size());
    end
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
